snn_infer_seq: RTL

//  Inference sequencer for the SNN core. Turns START/RESET pulses and TIMESTEPS from the main register bank into the
//  per-frame, per-bit-plane schedule: pop input FIFO -> CIM wordline phase -> ADC conversion -> neuron update.

---
 rtl/snn_soc_pkg.sv | 29 ++
 rtl/snn_seq_wdt.sv | 44 ++++
 rtl/snn_infer_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/snn_soc_pkg.sv
// Shared types and constants for the SNN core control path.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   seq_state_e     inference sequencer states
//   PIXEL_BITS      bit-planes per input frame (MSB first)
//   SEQ_WDT_CYCLES  default handshake watchdog limit
//   sat_inc16       saturating 16-bit increment
package snn_soc_pkg;

  localparam int PIXEL_BITS     = 8;
  localparam int SEQ_WDT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    CIM   = 3'd3,
    ADC   = 3'd4,
    UPD   = 3'd5,
    DONE  = 3'd6
  } seq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/snn_seq_wdt.sv
// Handshake watchdog: counts cycles spent in the sequencer's current state.
// Latency: expire is combinational from the count, asserted in the CYCLES-th cycle of a state.
// Backpressure: none; free-running, restarted by any state change.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   state     current sequencer state code
//   expire    high in the CYCLES-th consecutive cycle of the same state
module snn_seq_wdt #(
  parameter int CYCLES = snn_soc_pkg::SEQ_WDT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  output logic       expire
);
  import snn_soc_pkg::*;

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [2:0]    prev_state;
  logic          load;

  // A state change is the only way into a wait state, so comparing against the
  // previous state marks its first cycle without any help from the FSM.
  assign load   = (state != prev_state);
  assign expire = !load && (cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      prev_state <= IDLE;
    end else begin
      prev_state <= state;
      if (load) begin
        cnt <= CW'(1);
      end else if (!expire) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snn_infer_seq.sv
// Inference sequencer: frame/bit-plane schedule FIFO pop -> CIM -> ADC -> neuron update.
// Latency: every output registered; one clock edge per state change; idle start to first pop is 3 edges.
// Backpressure: stalls in FETCH on FIFO empty and in CIM/ADC until done; SNN_SEQ_WDT_EN bounds each wait.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start_pulse, soft_reset_pulse one-cycle commands from the register bank
//   timesteps                     frames per inference, captured at start
//   in_fifo_empty / in_fifo_pop   input word FIFO, one pop per frame
//   neuron_clear                  membrane clear at inference start
//   cim_start/cim_bit_idx/cim_done  wordline phase per bit-plane
//   adc_start/adc_done            conversion handshake
//   neuron_update                 integrate/fire strobe per bit-plane
//   snn_busy, snn_done_pulse, timestep_counter  status back to the register bank
//   dbg_wl_stall_cnt              saturating count of FETCH cycles with FIFO empty
//   seq_err                       sticky watchdog error (tied 0 without SNN_SEQ_WDT_EN)
module snn_infer_seq #(
  parameter int PIXEL_BITS = snn_soc_pkg::PIXEL_BITS,
  parameter int WDT_CYCLES = snn_soc_pkg::SEQ_WDT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_pulse,
  input  logic                          soft_reset_pulse,
  input  logic [7:0]                    timesteps,
  input  logic                          in_fifo_empty,
  output logic                          in_fifo_pop,
  output logic                          neuron_clear,
  output logic                          cim_start,
  output logic [$clog2(PIXEL_BITS)-1:0] cim_bit_idx,
  input  logic                          cim_done,
  output logic                          adc_start,
  input  logic                          adc_done,
  output logic                          neuron_update,
  output logic                          snn_busy,
  output logic                          snn_done_pulse,
  output logic [7:0]                    timestep_counter,
  output logic [15:0]                   dbg_wl_stall_cnt,
  output logic                          seq_err
);
  import snn_soc_pkg::*;

  localparam int            BW      = $clog2(PIXEL_BITS);
  localparam logic [BW-1:0] BIT_TOP = BW'(PIXEL_BITS - 1);

  seq_state_e state;
  logic [7:0] ts_lat;

`ifdef SNN_SEQ_WDT_EN
  logic wdt_expire;
  logic seq_err_q;

  snn_seq_wdt #(
    .CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .state  (state),
    .expire (wdt_expire)
  );

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ts_lat           <= '0;
      in_fifo_pop      <= 1'b0;
      neuron_clear     <= 1'b0;
      cim_start        <= 1'b0;
      cim_bit_idx      <= '0;
      adc_start        <= 1'b0;
      neuron_update    <= 1'b0;
      snn_busy         <= 1'b0;
      snn_done_pulse   <= 1'b0;
      timestep_counter <= '0;
      dbg_wl_stall_cnt <= '0;
`ifdef SNN_SEQ_WDT_EN
      seq_err_q        <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle: low unless the transition below raises them.
      in_fifo_pop    <= 1'b0;
      neuron_clear   <= 1'b0;
      cim_start      <= 1'b0;
      adc_start      <= 1'b0;
      neuron_update  <= 1'b0;
      snn_done_pulse <= 1'b0;

      if (soft_reset_pulse) begin
        // Abort wins over start and over any handshake seen this cycle.
        state    <= IDLE;
        snn_busy <= 1'b0;
`ifdef SNN_SEQ_WDT_EN
        seq_err_q <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start_pulse) begin
              ts_lat           <= timesteps;
              timestep_counter <= '0;
              dbg_wl_stall_cnt <= '0;
              snn_busy         <= 1'b1;
`ifdef SNN_SEQ_WDT_EN
              seq_err_q        <= 1'b0;
`endif
              if (timesteps == 8'd0) begin
                state          <= DONE;
                snn_done_pulse <= 1'b1;
              end else begin
                state        <= CLEAR;
                neuron_clear <= 1'b1;
              end
            end
          end

          CLEAR: begin
            state            <= FETCH;
            timestep_counter <= '0;
            cim_bit_idx      <= BIT_TOP;
          end

          FETCH: begin
            if (!in_fifo_empty) begin
              in_fifo_pop <= 1'b1;
              cim_start   <= 1'b1;
              state       <= CIM;
            end else begin
              dbg_wl_stall_cnt <= sat_inc16(dbg_wl_stall_cnt);
`ifdef SNN_SEQ_WDT_EN
              if (wdt_expire) begin
                state     <= IDLE;
                snn_busy  <= 1'b0;
                seq_err_q <= 1'b1;
              end
`endif
            end
          end

          CIM: begin
            // cim_done is looked at only here, so a stray pulse elsewhere is lost.
            if (cim_done) begin
              adc_start <= 1'b1;
              state     <= ADC;
            end
`ifdef SNN_SEQ_WDT_EN
            else if (wdt_expire) begin
              state     <= IDLE;
              snn_busy  <= 1'b0;
              seq_err_q <= 1'b1;
            end
`endif
          end

          ADC: begin
            if (adc_done) begin
              neuron_update <= 1'b1;
              state         <= UPD;
            end
`ifdef SNN_SEQ_WDT_EN
            else if (wdt_expire) begin
              state     <= IDLE;
              snn_busy  <= 1'b0;
              seq_err_q <= 1'b1;
            end
`endif
          end

          UPD: begin
            if (cim_bit_idx != '0) begin
              // Next bit-plane of the same input word: no pop.
              cim_bit_idx <= cim_bit_idx - 1'b1;
              cim_start   <= 1'b1;
              state       <= CIM;
            end else if (({1'b0, timestep_counter} + 9'd1) < {1'b0, ts_lat}) begin
              timestep_counter <= timestep_counter + 8'd1;
              cim_bit_idx      <= BIT_TOP;
              state            <= FETCH;
            end else begin
              snn_done_pulse <= 1'b1;
              state          <= DONE;
            end
          end

          DONE: begin
            state    <= IDLE;
            snn_busy <= 1'b0;
          end

          default: begin
            state    <= IDLE;
            snn_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
